ff_ram_wb_bridge: RTL and testbench
===================================

// Module: ff_ram_wb_bridge
// PURPOSE
//  Wishbone-classic slave that turns 32-bit word accesses into byte-serial accesses on a
//  byte-wide synchronous RAM (1 write port, 1 registered read port, 1-cycle read latency).
//  Sits between the CPU/data bus and the flip-flop data RAM.
//  Splits each word access into four byte beats and returns a single-cycle wb_ack.
//  Little-endian: byte i <-> wb_dat/wb_rdt[8i+7:8i], RAM address {word, i[1:0]}.
// PARAMETERS
//  aw  10  byte-address width of RAM and wb_adr (word index = wb_adr[aw-1:2])
// PORTS
//  clk        in   1      clock, all state on rising edge
//  reset_n    in   1      asynchronous, active-low reset
//  wb_adr     in   aw     byte address; [1:0] ignored
//  wb_dat     in   32     write data
//  wb_sel     in   4      byte enables (write only; reads always fetch 4 bytes)
//  wb_we      in   1      1=write 0=read
//  wb_stb     in   1      request strobe (cyc folded in)
//  wb_rdt     out  32     read data, valid while wb_ack=1 on reads
//  wb_ack     out  1      one-cycle completion pulse
//  ram_wen    out  1      RAM byte write enable
//  ram_waddr  out  aw     RAM write address
//  ram_din    out  8      RAM write data
//  ram_raddr  out  aw     RAM read address
//  ram_dout   in   8      RAM read data, valid 1 cycle after ram_raddr
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, cnt=0, wb_ack=0, ram_wen=0, wb_rdt=0, ram_waddr=0,
//   ram_raddr=0, ram_din=0. Reset mid-access aborts it; bytes already written stay in RAM,
//   no ack is issued.
//  FSM states IDLE, WRITE, READ, DRAIN, ACK; 2-bit beat counter cnt.
//  IDLE: wb_stb=1 -> register adr[aw-1:2], dat, sel, we; cnt<=0; go WRITE (we) or READ.
//  WRITE (cnt 0..3): ram_waddr={adr_q,cnt}, ram_din=dat_q byte cnt, ram_wen=sel_q[cnt];
//   cnt==3 -> ACK.
//  READ (cnt 0..3): ram_raddr={adr_q,cnt}; when cnt>=1 capture ram_dout into wb_rdt byte cnt-1;
//   cnt==3 -> DRAIN.
//  DRAIN: capture ram_dout into wb_rdt byte 3; go ACK.
//  ACK: wb_ack=1 for exactly one cycle; go IDLE. wb_rdt holds until next read capture.
//  Latency (stb sampled in cycle 0): write ack in cycle 5, read ack in cycle 6.
//  Master must drop wb_stb in the cycle after ack. IDLE does not accept while in ACK,
//   so there are no back-to-back accepts without an IDLE cycle.
//  wb_adr/dat/sel/we changes after acceptance are ignored (registered copies used).
//  Write with wb_sel=0000: four beats, ram_wen never asserted, still acked in cycle 5.
//  Word at top of RAM (adr_q all ones): byte addresses wrap only within the word. No overflow.
//  ram_wen only in WRITE; ram outputs outside their states hold last value.
// CONFIGURATION
//  FF_RAM_BRIDGE_SKIP_EN defined: WRITE visits only bytes with sel_q[i]=1, ascending order.
//   Write ack cycle = 1 + popcount(sel) + (sel!=0 ? 0 : 0); sel=0000 goes IDLE->ACK, ack in cycle 1.
//   Reads unchanged.
//  Undefined: fixed 4-beat writes as above.
// TESTING
//  reset_n=0 mid-WRITE (cycle 2) -> wb_ack/ram_wen drop same cycle; bytes 0..1 written, 2..3 not.
//  write adr=0x010 dat=0xA1B2C3D4 sel=1111 -> wen at bytes 0x10..0x13 = D4,C3,B2,A1; ack cycle 5.
//  write adr=0x014 dat=0x11223344 sel=0101 -> only 0x14=44, 0x16=22 written;
//   ack cycle 5 (SKIP_EN: cycle 3).
//  read adr=0x010 after test 2 -> wb_rdt=0xA1B2C3D4 with ack in cycle 6, ack exactly 1 cycle.
//  write adr=0x3FC sel=1111 then read 0x3FC -> data round-trips, no address wrap outside word.
//  write sel=0000 -> no ram_wen pulse, ack cycle 5 (SKIP_EN: cycle 1).

Source files
------------

// File: rtl/ff_ram_wb_bridge_if.sv
// Wishbone-classic bus bundle between a CPU/data-bus master and the
// flip-flop RAM bridge. Cycle is folded into stb.
interface ff_ram_wb_bridge_if #(
   parameter int aw = 10
) ();
   logic [aw-1:0] adr;
   logic [31:0]   dat;
   logic [3:0]    sel;
   logic          we;
   logic          stb;
   logic [31:0]   rdt;
   logic          ack;

   modport master (
      output adr, dat, sel, we, stb,
      input  rdt, ack
   );

   modport slave (
      input  adr, dat, sel, we, stb,
      output rdt, ack
   );
endinterface

// File: rtl/ff_ram_wb_bridge.sv
// Wishbone-classic slave that serialises 32-bit word accesses into byte
// beats on a byte-wide synchronous RAM (registered read, 1-cycle latency).
// Little-endian: byte i of the word lives at RAM address {word, i}.
// Optional build macro FF_RAM_BRIDGE_SKIP_EN: writes visit only the bytes
// whose select bit is set (ascending), a write with no bytes selected goes
// straight to the acknowledge. Reads always fetch all four bytes.
module ff_ram_wb_bridge #(
   parameter int aw = 10
) (
   input  logic                 clk,
   input  logic                 reset_n,
   ff_ram_wb_bridge_if.slave    wb,
   output logic                 ram_wen,
   output logic [aw-1:0]        ram_waddr,
   output logic [7:0]           ram_din,
   output logic [aw-1:0]        ram_raddr,
   input  logic [7:0]           ram_dout
);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      WRITE = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      ACK   = 3'd4
   } state_t;

   state_t         state, state_nxt;
   logic [1:0]     cnt, cnt_nxt;

   logic [aw-3:0]  adr_q;
   logic [31:0]    dat_q;
   logic [3:0]     sel_q;

   logic [31:0]    rdt_q;
   logic [aw-1:0]  waddr_q;
   logic [aw-1:0]  raddr_q;
   logic [7:0]     din_q;

   // Byte lane of a 32-bit word, little-endian.
   function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] idx);
      logic [7:0] b;
      case (idx)
         2'd0:    b = w[7:0];
         2'd1:    b = w[15:8];
         2'd2:    b = w[23:16];
         default: b = w[31:24];
      endcase
      return b;
   endfunction

`ifdef FF_RAM_BRIDGE_SKIP_EN
   // Lowest selected byte index at or above 'from'; bit 2 flags that one exists.
   function automatic logic [2:0] next_sel(input logic [3:0] s, input logic [2:0] from);
      logic [2:0] r;
      r = 3'b000;
      for (int i = 3; i >= 0; i--) begin
         if (i >= int'(from) && s[i]) r = {1'b1, 2'(i)};
      end
      return r;
   endfunction

   logic [2:0] nx_idle, nx_write;
   assign nx_idle  = next_sel(wb.sel, 3'd0);
   assign nx_write = next_sel(sel_q, {1'b0, cnt} + 3'd1);
`endif

   // The word index alone addresses the RAM; the byte offset of wb.adr is dropped.
   logic unused_adr_lo;
   assign unused_adr_lo = ^wb.adr[1:0];

   // State and beat counter.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         cnt   <= 2'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Next-state and beat sequencing.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (wb.stb) begin
               cnt_nxt = 2'd0;
               if (wb.we) begin
`ifdef FF_RAM_BRIDGE_SKIP_EN
                  if (nx_idle[2]) begin
                     state_nxt = WRITE;
                     cnt_nxt   = nx_idle[1:0];
                  end else begin
                     state_nxt = ACK;
                  end
`else
                  state_nxt = WRITE;
`endif
               end else begin
                  state_nxt = READ;
               end
            end
         end
         WRITE: begin
`ifdef FF_RAM_BRIDGE_SKIP_EN
            if (nx_write[2]) begin
               cnt_nxt = nx_write[1:0];
            end else begin
               state_nxt = ACK;
               cnt_nxt   = 2'd0;
            end
`else
            cnt_nxt = cnt + 2'd1;
            if (cnt == 2'd3) state_nxt = ACK;
`endif
         end
         READ: begin
            cnt_nxt = cnt + 2'd1;
            if (cnt == 2'd3) state_nxt = DRAIN;
         end
         DRAIN:   state_nxt = ACK;
         ACK:     state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Request capture at acceptance; later bus changes are ignored.
   always_ff @(posedge clk) begin
      if (state == IDLE && wb.stb) begin
         adr_q <= wb.adr[aw-1:2];
         dat_q <= wb.dat;
         sel_q <= wb.sel;
      end
   end

   // Hold the last RAM addresses/data so they stay stable outside their states.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         waddr_q <= '0;
         din_q   <= '0;
         raddr_q <= '0;
      end else begin
         if (state == WRITE) begin
            waddr_q <= {adr_q, cnt};
            din_q   <= byte_of(dat_q, cnt);
         end
         if (state == READ) raddr_q <= {adr_q, cnt};
      end
   end

   // Read data assembly: RAM data trails the address by one beat.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rdt_q <= '0;
      end else if (state == READ && cnt != 2'd0) begin
         case (cnt)
            2'd1:    rdt_q[7:0]   <= ram_dout;
            2'd2:    rdt_q[15:8]  <= ram_dout;
            default: rdt_q[23:16] <= ram_dout;
         endcase
      end else if (state == DRAIN) begin
         rdt_q[31:24] <= ram_dout;
      end
   end

   assign ram_wen   = (state == WRITE) && sel_q[cnt];
   assign ram_waddr = (state == WRITE) ? {adr_q, cnt} : waddr_q;
   assign ram_din   = (state == WRITE) ? byte_of(dat_q, cnt) : din_q;
   assign ram_raddr = (state == READ)  ? {adr_q, cnt} : raddr_q;
   assign wb.ack    = (state == ACK);
   assign wb.rdt    = rdt_q;

endmodule

// File: tb/tb_ff_ram_wb_bridge.sv
// Testbench for ff_ram_wb_bridge: a byte RAM with registered read sits on
// the RAM side; a word-level memory model predicts read data, RAM contents,
// write-enable pulse counts and acknowledge latency.
module tb_ff_ram_wb_bridge;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          ram_wen;
   logic [AW-1:0] ram_waddr;
   logic [7:0]    ram_din;
   logic [AW-1:0] ram_raddr;
   logic [7:0]    ram_dout;

   ff_ram_wb_bridge_if #(.aw(AW)) wbi ();

   ff_ram_wb_bridge #(.aw(AW)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .wb        (wbi.slave),
      .ram_wen   (ram_wen),
      .ram_waddr (ram_waddr),
      .ram_din   (ram_din),
      .ram_raddr (ram_raddr),
      .ram_dout  (ram_dout)
   );

   always #5 clk = ~clk;

   // Byte RAM seen by the bridge.
   logic [7:0] ram [0:(1<<AW)-1] = '{default: 8'h00};
   always @(posedge clk) begin
      if (ram_wen) ram[ram_waddr] <= ram_din;
      ram_dout <= ram[ram_raddr];
   end

   // Write-enable observer.
   int          wen_total = 0;
   int          bad_total = 0;
   logic [AW-3:0] cur_word = '0;
   always @(negedge clk) begin
      if (ram_wen) begin
         wen_total++;
         if (ram_waddr[AW-1:2] !== cur_word) bad_total++;
      end
   end

   // Reference model: word-level view of memory and last read data.
   logic [7:0]  exp_mem [0:(1<<AW)-1];
   logic [31:0] last_rdt;
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] exp_word(input logic [AW-3:0] w);
      int base;
      base = int'(w) * 4;
      return {exp_mem[base+3], exp_mem[base+2], exp_mem[base+1], exp_mem[base]};
   endfunction

   function automatic logic [31:0] ram_word(input logic [AW-3:0] w);
      int base;
      base = int'(w) * 4;
      return {ram[base+3], ram[base+2], ram[base+1], ram[base]};
   endfunction

   task automatic txn(input logic we, input logic [AW-1:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input string tag);
      int got;
      int w0, b0;
      int exp_lat;
      got = -1;
      @(posedge clk); #1;
      cur_word = adr[AW-1:2];
      w0 = wen_total;
      b0 = bad_total;
      wbi.adr = adr; wbi.dat = dat; wbi.sel = sel; wbi.we = we; wbi.stb = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (wbi.ack === 1'b1) begin
            got = k;
            break;
         end
         if (k >= 1) begin
            wbi.adr = AW'($urandom);
            wbi.dat = $urandom;
            wbi.sel = 4'($urandom);
            wbi.we  = 1'($urandom);
         end
      end
      if (got < 0) begin
         chk({tag, "_ack_timeout"}, 32'd0, 32'd1);
         wbi.stb = 1'b0;
         return;
      end
      if (we) begin
`ifdef FF_RAM_BRIDGE_SKIP_EN
         exp_lat = 1 + $countones(sel);
`else
         exp_lat = 5;
`endif
         for (int i = 0; i < 4; i++)
            if (sel[i]) exp_mem[int'(adr[AW-1:2]) * 4 + i] = dat[8*i +: 8];
         chk({tag, "_rdt_hold"}, wbi.rdt, last_rdt);
      end else begin
         exp_lat = 6;
         last_rdt = exp_word(adr[AW-1:2]);
         chk({tag, "_rdt"}, wbi.rdt, last_rdt);
      end
      chk({tag, "_ack_cycle"}, 32'(got), 32'(exp_lat));
      wbi.stb = 1'b0;
      @(negedge clk);
      chk({tag, "_ack_single"}, 32'(wbi.ack), 32'd0);
      chk({tag, "_wen_count"}, 32'(wen_total - w0), we ? 32'($countones(sel)) : 32'd0);
      chk({tag, "_wen_addr"}, 32'(bad_total - b0), 32'd0);
      if (we) chk({tag, "_ram"}, ram_word(adr[AW-1:2]), exp_word(adr[AW-1:2]));
   endtask

   initial begin
      logic [AW-1:0] radr;
      logic [31:0]   rdat;
      for (int i = 0; i < (1<<AW); i++) exp_mem[i] = 8'h00;
      last_rdt = 32'd0;
      wbi.adr = '0; wbi.dat = '0; wbi.sel = '0; wbi.we = 1'b0; wbi.stb = 1'b0;

      // Reset state.
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ack",   32'(wbi.ack), 32'd0);
      chk("rst_wen",   32'(ram_wen), 32'd0);
      chk("rst_rdt",   wbi.rdt, 32'd0);
      chk("rst_waddr", 32'(ram_waddr), 32'd0);
      chk("rst_raddr", 32'(ram_raddr), 32'd0);
      chk("rst_din",   32'(ram_din), 32'd0);
      reset_n = 1'b1;

      // Directed cases.
      txn(1'b1, 10'h010, 32'hA1B2C3D4, 4'b1111, "wr_full");
      txn(1'b1, 10'h014, 32'h11223344, 4'b0101, "wr_sel0101");
      txn(1'b0, 10'h010, 32'h0,        4'b0000, "rd_010");
      chk("rd_010_value", last_rdt, 32'hA1B2C3D4);
      txn(1'b0, 10'h014, 32'h0,        4'b1111, "rd_014");
      chk("rd_014_value", last_rdt, 32'h00220044);
      txn(1'b1, 10'h3FC, 32'h5A6B7C8D, 4'b1111, "wr_top");
      txn(1'b0, 10'h3FC, 32'h0,        4'b0000, "rd_top");
      chk("rd_top_value", last_rdt, 32'h5A6B7C8D);
      chk("top_no_wrap", ram_word(8'h00), 32'h00000000);
      txn(1'b1, 10'h010, 32'hFFFFFFFF, 4'b0000, "wr_sel0");
      txn(1'b0, 10'h010, 32'h0,        4'b0000, "rd_after_sel0");
      chk("sel0_unchanged", last_rdt, 32'hA1B2C3D4);

      // Randomized traffic over a few hot words plus random ones.
      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 4))
            0:       radr = 10'h004;
            1:       radr = 10'h010;
            2:       radr = 10'h3FC;
            3:       radr = 10'h014;
            default: radr = AW'($urandom);
         endcase
         radr[1:0] = 2'($urandom);
         rdat = $urandom;
         txn(1'($urandom), radr, rdat, 4'($urandom), "rand");
      end

      // Reset in the middle of a write: two bytes land, no acknowledge.
      @(posedge clk); #1;
      cur_word = 8'h08;
      wbi.adr = 10'h020; wbi.dat = 32'hCAFEBABE; wbi.sel = 4'b1111; wbi.we = 1'b1; wbi.stb = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_ack",   32'(wbi.ack), 32'd0);
      chk("midrst_wen",   32'(ram_wen), 32'd0);
      chk("midrst_rdt",   wbi.rdt, 32'd0);
      chk("midrst_waddr", 32'(ram_waddr), 32'd0);
      chk("midrst_din",   32'(ram_din), 32'd0);
      exp_mem[32'h20] = 8'hBE;
      exp_mem[32'h21] = 8'hBA;
      last_rdt = 32'd0;
      wbi.stb = 1'b0;
      @(posedge clk); #1;
      chk("midrst_ram", ram_word(8'h08), exp_word(8'h08));
      reset_n = 1'b1;
      txn(1'b0, 10'h020, 32'h0, 4'b0000, "rd_after_rst");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
